// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - fetch/decode/execute/write control FSM; CONTADOR_INSTR_EN enables the retired-instruction counter
module unidade_controle #(
    parameter int bits_palavra  = 16,
    parameter int end_registros = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [bits_palavra-1:0]  instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    output logic                     Hab_Escrita,
    output logic [end_registros-1:0] Sel_SA,
    output logic [end_registros-1:0] Sel_SB,
    output logic [end_registros-1:0] Sel_SC,
    output logic [4:0]               controleOperacao,
    output logic                     reset_Flags,
    output logic [15:0]              instr_count,
    output logic                     parado
);

    localparam logic [4:0] OP_CLRF = 5'b11110;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {
        BUSCA,
        DECODIFICA,
        EXECUTA,
        ESCRITA,
        PARADO
    } estado_t;

    estado_t                  estado, proximo;
    logic [4:0]               op_q;
    logic [end_registros-1:0] sc_q, sa_q, sb_q;
    logic                     handshake;
    logic                     unused_bits;

    assign handshake   = (estado == BUSCA) && instr_valid;
    assign unused_bits = ^instr[4:0];

    // Latched fields only change on a handshake, so they hold through BUSCA.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= BUSCA;
            op_q   <= '0;
            sc_q   <= '0;
            sa_q   <= '0;
            sb_q   <= '0;
        end else begin
            estado <= proximo;
            if (handshake) begin
                op_q <= instr[15:11];
                sc_q <= instr[9 +: end_registros];
                sa_q <= instr[7 +: end_registros];
                sb_q <= instr[5 +: end_registros];
            end
        end
    end

    always_comb begin
        proximo     = estado;
        instr_ready = 1'b0;
        Hab_Escrita = 1'b0;
        reset_Flags = 1'b0;
        parado      = 1'b0;
        case (estado)
            BUSCA: begin
                instr_ready = 1'b1;
                if (instr_valid) proximo = DECODIFICA;
            end
            DECODIFICA: proximo = EXECUTA;
            EXECUTA:    proximo = ESCRITA;
            ESCRITA: begin
                Hab_Escrita = (op_q != OP_CLRF) && (op_q != OP_HALT);
                reset_Flags = (op_q == OP_CLRF);
                proximo     = (op_q == OP_HALT) ? PARADO : BUSCA;
            end
            PARADO: parado = 1'b1;
            default: proximo = BUSCA;
        endcase
    end

    assign controleOperacao = op_q;
    assign Sel_SA           = sa_q;
    assign Sel_SB           = sb_q;
    assign Sel_SC           = sc_q;

`ifdef CONTADOR_INSTR_EN
    logic [15:0] count_q;

    // Every ESCRITA cycle is an exit from ESCRITA, HALT included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else if (estado == ESCRITA) count_q <= count_q + 16'd1;
    end

    assign instr_count = count_q;
`else
    assign instr_count = '0;
`endif

endmodule
